// File: rtl/mem_arbiter.sv
// Shares one memory port between an I-cache and a D-cache. Grants alternate under
// contention, memory commands are registered, and completions are passed straight through.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t            r_state;
    state_t            w_next_state;
    grant_t            r_last_grant;
    grant_t            w_next_last_grant;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_done;
    logic              w_i_ready;
    logic              w_d_ready;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    assign w_i_req = i_mem_read;
    assign w_d_req = d_mem_read | d_mem_write;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_grant_i         = 1'b0;
        w_grant_d         = 1'b0;
        w_done            = 1'b0;
        w_i_ready         = 1'b0;
        w_d_ready         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Under contention the client that was not served last wins.
                if (w_d_req && (!w_i_req || r_last_grant == GRANT_I)) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ST_D_BUSY;
                end else if (w_i_req) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ST_I_BUSY;
                end
            end
            ST_I_BUSY: begin
                if (mem_ready) begin
                    w_done            = 1'b1;
                    w_i_ready         = 1'b1;
                    w_next_state      = ST_IDLE;
                    w_next_last_grant = GRANT_I;
                end
            end
            ST_D_BUSY: begin
                if (mem_ready) begin
                    w_done            = 1'b1;
                    w_d_ready         = 1'b1;
                    w_next_state      = ST_IDLE;
                    w_next_last_grant = GRANT_D;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: flops take non-blocking assignments so all of them update from pre-edge values.
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_I;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // A simultaneous read and write from the D-cache issues the write; the read is re-requested later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_i) begin
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= i_mem_addr;
            r_mem_wdata <= '0;
        end else if (w_grant_d) begin
            r_mem_read  <= ~d_mem_write;
            r_mem_write <= d_mem_write;
            r_mem_addr  <= d_mem_addr;
            r_mem_wdata <= d_mem_write ? d_mem_wdata : '0;
        end else if (w_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

    // Reset is synchronous, so the combinational outputs are gated to stay quiet before the reset edge.
    assign i_mem_ready = w_i_ready & rst_n;
    assign d_mem_ready = w_d_ready & rst_n;
    assign busy        = rst_n & (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run scored against a
// transaction-level model of who is being served and what command they should see.
module tb_mem_arbiter;

    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_mem_read = 1'b0;
    logic [27:0]  i_mem_addr = '0;
    logic [127:0] i_mem_rdata;
    logic         i_mem_ready;
    logic         d_mem_read = 1'b0;
    logic         d_mem_write = 1'b0;
    logic [27:0]  d_mem_addr = '0;
    logic [127:0] d_mem_wdata = '0;
    logic [127:0] d_mem_rdata;
    logic         d_mem_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    // memory responder controls
    bit           mem_auto = 1'b1;
    int           mem_lat_fix = 0;
    bit           mem_data_fix = 1'b0;
    logic [127:0] mem_data_val = '0;
    int           mem_cnt = 0;
    int           mem_lat = 1;

    // reference model: current owner, last owner served, and the command it must see
    int           m_owner = OWN_NONE;
    int           m_last = OWN_I;
    logic         exp_read = 1'b0;
    logic         exp_write = 1'b0;
    logic [27:0]  exp_addr = '0;
    logic [127:0] exp_wdata = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_read  (i_mem_read),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_ready (d_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached, required finish before 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Applies the serving rules to the inputs that were held across the edge just taken.
    task automatic model_edge();
        if (!rst_n) begin
            m_owner   = OWN_NONE;
            m_last    = OWN_I;
            exp_read  = 1'b0;
            exp_write = 1'b0;
            exp_addr  = '0;
            exp_wdata = '0;
        end else if (m_owner == OWN_NONE) begin
            if ((d_mem_read || d_mem_write) && (!i_mem_read || m_last == OWN_I)) begin
                m_owner   = OWN_D;
                exp_write = d_mem_write;
                exp_read  = !d_mem_write;
                exp_addr  = d_mem_addr;
                exp_wdata = d_mem_write ? d_mem_wdata : '0;
            end else if (i_mem_read) begin
                m_owner   = OWN_I;
                exp_read  = 1'b1;
                exp_write = 1'b0;
                exp_addr  = i_mem_addr;
                exp_wdata = '0;
            end
        end else if (mem_ready) begin
            m_last    = m_owner;
            m_owner   = OWN_NONE;
            exp_read  = 1'b0;
            exp_write = 1'b0;
        end
    endtask

    task automatic memory_drive();
        if (mem_auto) begin
            mem_rdata = mem_data_fix ? mem_data_val : rand128();
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_read === 1'b1 || mem_write === 1'b1) begin
                if (mem_cnt == 0) mem_lat = (mem_lat_fix > 0) ? mem_lat_fix : int'($urandom_range(1, 4));
                if (mem_cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_cnt   = 0;
                end else begin
                    mem_cnt++;
                end
            end
        end
    endtask

    // One clock: model and memory react at edge+1, outputs are settled for sampling at edge+2.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        memory_drive();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        d_mem_write = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        mem_cnt = 0;
    endtask

    task automatic test_reset();
        mem_auto = 1'b0;
        rst_n = 1'b0;
        i_mem_read = 1'b1;
        i_mem_addr = 28'($urandom());
        d_mem_read = 1'b1;
        d_mem_write = 1'b1;
        d_mem_addr = 28'($urandom());
        d_mem_wdata = rand128();
        cycle();
        cycle();
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
        n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 128'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (i_mem_ready !== 1'b0) begin n_bad++; $display("FAIL rst_i_ready: got %b want 0", i_mem_ready); end
        n_cmp++; if (d_mem_ready !== 1'b0) begin n_bad++; $display("FAIL rst_d_ready: got %b want 0", d_mem_ready); end
        mem_ready = 1'b0;
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        d_mem_write = 1'b0;
        rst_n = 1'b1;
        cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
        mem_auto = 1'b1;
        mem_cnt = 0;
    endtask

    task automatic test_single_fill();
        int cmd_cyc = -1;
        int rdy_cyc = -1;
        int n_rdy = 0;
        bit d_seen = 1'b0;
        mem_lat_fix = 3;
        mem_data_fix = 1'b1;
        mem_data_val = {16{8'hA5}};
        i_mem_read = 1'b1;
        i_mem_addr = 28'h0000010;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (mem_read === 1'b1 && cmd_cyc < 0) begin
                cmd_cyc = c;
                n_cmp++; if (mem_addr !== 28'h0000010) begin n_bad++; $display("FAIL fill_addr: got %h want 0000010", mem_addr); end
                n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL fill_write: got %b want 0", mem_write); end
                n_cmp++; if (mem_wdata !== 128'h0) begin n_bad++; $display("FAIL fill_wdata: got %h want 0", mem_wdata); end
            end
            if (d_mem_ready !== 1'b0) d_seen = 1'b1;
            if (i_mem_ready === 1'b1) begin
                n_rdy++;
                rdy_cyc = c;
                n_cmp++; if (i_mem_rdata !== {16{8'hA5}}) begin n_bad++; $display("FAIL fill_rdata: got %h want a5..a5", i_mem_rdata); end
                i_mem_read = 1'b0;
            end
        end
        n_cmp++; if (cmd_cyc != 0) begin n_bad++; $display("FAIL fill_cmd_cycle: got %0d want 0", cmd_cyc); end
        n_cmp++; if (rdy_cyc != 3) begin n_bad++; $display("FAIL fill_ready_cycle: got %0d want 3", rdy_cyc); end
        n_cmp++; if (n_rdy != 1) begin n_bad++; $display("FAIL fill_ready_count: got %0d want 1", n_rdy); end
        n_cmp++; if (d_seen) begin n_bad++; $display("FAIL fill_d_ready: got 1 want 0"); end
        mem_data_fix = 1'b0;
    endtask

    task automatic test_min_latency();
        int rdy_cyc = -1;
        mem_lat_fix = 1;
        i_mem_read = 1'b1;
        i_mem_addr = 28'($urandom());
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (i_mem_ready === 1'b1 && rdy_cyc < 0) begin
                rdy_cyc = c;
                n_cmp++; if (i_mem_rdata !== mem_rdata) begin n_bad++; $display("FAIL minlat_rdata: got %h want %h", i_mem_rdata, mem_rdata); end
                i_mem_read = 1'b0;
            end
        end
        n_cmp++; if (rdy_cyc != 1) begin n_bad++; $display("FAIL minlat_cycle: got %0d want 1", rdy_cyc); end
        mem_lat_fix = 0;
    endtask

    task automatic test_contention();
        int grants[$];
        int n_i = 0;
        int n_d = 0;
        int cur = OWN_NONE;
        bit prev_busy = 1'b0;
        bit prev_rdy = 1'b0;
        do_reset();
        mem_lat_fix = 0;
        i_mem_read = 1'b1;
        i_mem_addr = 28'h1111111;
        d_mem_read = 1'b1;
        d_mem_addr = 28'h2222222;
        for (int c = 0; c < 100 && (n_i + n_d) < 4; c++) begin
            cycle();
            if (prev_rdy) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_gap: busy %b want 0 after ready", busy); end
            end
            if (busy === 1'b1 && !prev_busy) begin
                cur = (mem_addr == 28'h2222222) ? OWN_D : ((mem_addr == 28'h1111111) ? OWN_I : OWN_NONE);
                grants.push_back(cur);
            end
            n_cmp++; if ((i_mem_ready & d_mem_ready) !== 1'b0) begin n_bad++; $display("FAIL cont_overlap: i %b d %b want not both", i_mem_ready, d_mem_ready); end
            if (i_mem_ready === 1'b1) begin
                n_i++;
                n_cmp++; if (cur != OWN_I) begin n_bad++; $display("FAIL cont_i_owner: owner %0d want %0d", cur, OWN_I); end
            end
            if (d_mem_ready === 1'b1) begin
                n_d++;
                n_cmp++; if (cur != OWN_D) begin n_bad++; $display("FAIL cont_d_owner: owner %0d want %0d", cur, OWN_D); end
            end
            prev_rdy = (i_mem_ready === 1'b1) || (d_mem_ready === 1'b1);
            prev_busy = (busy === 1'b1);
        end
        n_cmp++; if (n_i != 2) begin n_bad++; $display("FAIL cont_i_count: got %0d want 2", n_i); end
        n_cmp++; if (n_d != 2) begin n_bad++; $display("FAIL cont_d_count: got %0d want 2", n_d); end
        n_cmp++; if (grants.size() != 4) begin n_bad++; $display("FAIL cont_grants: got %0d want 4", grants.size()); end
        for (int k = 0; k < grants.size() && k < 4; k++) begin
            n_cmp++;
            if (grants[k] != ((k % 2 == 0) ? OWN_D : OWN_I)) begin
                n_bad++;
                $display("FAIL cont_order[%0d]: got %0d want %0d", k, grants[k], (k % 2 == 0) ? OWN_D : OWN_I);
            end
        end
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_write_back();
        int phase = 0;
        bit prev_busy = 1'b0;
        logic [127:0] wd;
        wd = 128'h1234_5678_1234_5678_1234_5678_1234_5678;
        d_mem_read = 1'b1;
        d_mem_write = 1'b1;
        d_mem_addr = 28'h0ABCDEF;
        d_mem_wdata = wd;
        for (int c = 0; c < 40 && phase < 2; c++) begin
            cycle();
            if (busy === 1'b1 && !prev_busy) begin
                n_cmp++; if (mem_addr !== 28'h0ABCDEF) begin n_bad++; $display("FAIL wb_addr%0d: got %h want 0abcdef", phase, mem_addr); end
                n_cmp++; if (mem_write !== (phase == 0)) begin n_bad++; $display("FAIL wb_write%0d: got %b want %b", phase, mem_write, phase == 0); end
                n_cmp++; if (mem_read !== (phase == 1)) begin n_bad++; $display("FAIL wb_read%0d: got %b want %b", phase, mem_read, phase == 1); end
                n_cmp++; if (mem_wdata !== ((phase == 0) ? wd : 128'h0)) begin n_bad++; $display("FAIL wb_wdata%0d: got %h", phase, mem_wdata); end
            end
            n_cmp++; if (i_mem_ready !== 1'b0) begin n_bad++; $display("FAIL wb_i_ready: got %b want 0", i_mem_ready); end
            if (d_mem_ready === 1'b1) begin
                if (phase == 0) d_mem_write = 1'b0;
                else d_mem_read = 1'b0;
                phase++;
            end
            prev_busy = (busy === 1'b1);
        end
        n_cmp++; if (phase != 2) begin n_bad++; $display("FAIL wb_done: got %0d transactions want 2", phase); end
        d_mem_read = 1'b0;
        d_mem_write = 1'b0;
        cycle();
    endtask

    task automatic test_stray_and_reset();
        mem_auto = 1'b0;
        mem_ready = 1'b0;
        cycle();
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ((i_mem_ready | d_mem_ready) !== 1'b0) begin n_bad++; $display("FAIL stray_ready: i %b d %b want 0", i_mem_ready, d_mem_ready); end
        cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stray_busy: got %b want 0", busy); end
        n_cmp++; if ((mem_read | mem_write) !== 1'b0) begin n_bad++; $display("FAIL stray_cmd: rd %b wr %b want 0", mem_read, mem_write); end
        mem_ready = 1'b0;
        d_mem_read = 1'b1;
        d_mem_addr = 28'($urandom());
        cycle();
        cycle();
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL abort_cmd: got %b want 1", mem_read); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        mem_ready = 1'b1;
        d_mem_read = 1'b0;
        #1;
        n_cmp++; if (d_mem_ready !== 1'b0) begin n_bad++; $display("FAIL abort_rst_ready: got %b want 0", d_mem_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_rst_busy: got %b want 0", busy); end
        cycle();
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL abort_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL abort_mem_addr: got %h want 0", mem_addr); end
        rst_n = 1'b1;
        cycle();
        n_cmp++; if (d_mem_ready !== 1'b0) begin n_bad++; $display("FAIL late_ready: got %b want 0", d_mem_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL late_busy: got %b want 0", busy); end
        mem_ready = 1'b0;
        cycle();
        mem_auto = 1'b1;
        mem_cnt = 0;
    endtask

    task automatic test_random();
        bit i_pend = 1'b0;
        bit d_pend = 1'b0;
        logic exp_i_rdy;
        logic exp_d_rdy;
        int op;
        do_reset();
        mem_lat_fix = 0;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            exp_i_rdy = rst_n && (m_owner == OWN_I) && mem_ready;
            exp_d_rdy = rst_n && (m_owner == OWN_D) && mem_ready;
            n_cmp++; if (busy !== (rst_n && m_owner != OWN_NONE)) begin n_bad++; $display("FAIL rnd_busy@%0d: got %b owner %0d", c, busy, m_owner); end
            n_cmp++; if (mem_read !== exp_read) begin n_bad++; $display("FAIL rnd_read@%0d: got %b want %b", c, mem_read, exp_read); end
            n_cmp++; if (mem_write !== exp_write) begin n_bad++; $display("FAIL rnd_write@%0d: got %b want %b", c, mem_write, exp_write); end
            if (m_owner != OWN_NONE) begin
                n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_addr@%0d: got %h want %h", c, mem_addr, exp_addr); end
                n_cmp++; if (mem_wdata !== exp_wdata) begin n_bad++; $display("FAIL rnd_wdata@%0d: got %h want %h", c, mem_wdata, exp_wdata); end
            end
            n_cmp++; if (i_mem_ready !== exp_i_rdy) begin n_bad++; $display("FAIL rnd_i_ready@%0d: got %b want %b", c, i_mem_ready, exp_i_rdy); end
            n_cmp++; if (d_mem_ready !== exp_d_rdy) begin n_bad++; $display("FAIL rnd_d_ready@%0d: got %b want %b", c, d_mem_ready, exp_d_rdy); end
            if (exp_i_rdy) begin
                n_cmp++; if (i_mem_rdata !== mem_rdata) begin n_bad++; $display("FAIL rnd_i_rdata@%0d: got %h want %h", c, i_mem_rdata, mem_rdata); end
            end
            if (exp_d_rdy) begin
                n_cmp++; if (d_mem_rdata !== mem_rdata) begin n_bad++; $display("FAIL rnd_d_rdata@%0d: got %h want %h", c, d_mem_rdata, mem_rdata); end
            end

            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                i_pend = 1'b0;
                d_pend = 1'b0;
                i_mem_read = 1'b0;
                d_mem_read = 1'b0;
                d_mem_write = 1'b0;
                mem_cnt = 0;
            end else begin
                rst_n = 1'b1;
                if (i_pend && i_mem_ready === 1'b1) i_pend = 1'b0;
                if (i_pend && $urandom_range(0, 99) < 2) begin
                    i_pend = 1'b0;
                    i_mem_read = 1'b0;
                end else if (!i_pend) begin
                    i_mem_read = 1'b0;
                    if ($urandom_range(0, 3) == 0) begin
                        i_pend = 1'b1;
                        i_mem_read = 1'b1;
                        i_mem_addr = 28'($urandom());
                    end
                end
                if (d_pend && d_mem_ready === 1'b1) begin
                    if (d_mem_read && d_mem_write) d_mem_write = 1'b0;
                    else d_pend = 1'b0;
                end
                if (d_pend && $urandom_range(0, 99) < 2) begin
                    d_pend = 1'b0;
                    d_mem_read = 1'b0;
                    d_mem_write = 1'b0;
                end else if (!d_pend) begin
                    d_mem_read = 1'b0;
                    d_mem_write = 1'b0;
                    if ($urandom_range(0, 3) == 0) begin
                        op = int'($urandom_range(0, 2));
                        d_pend = 1'b1;
                        d_mem_read = (op != 1);
                        d_mem_write = (op != 0);
                        d_mem_addr = 28'($urandom());
                        d_mem_wdata = rand128();
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_min_latency();
        test_contention();
        test_write_back();
        test_stray_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
